intra_pred_seq: RTL and testbench

Sequential, parametrised luma/chroma intra predictor for the encoder's prediction stage. It supports four modes: DC, TrueMotion (TM), Vertical (V) and Horizontal (H). It works for square blocks of 4, 8 or 16 pixels, with substitution of missing edge pixels. Neighbour pixels are captured on a start handshake and the predicted block is streamed one row per cycle under valid/ready backpressure. The residual/SAD unit downstream consumes the rows directly.

---
 rtl/intra_pred_seq.sv | 205 ++++++++++++++++++++
 tb/tb_intra_pred_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_pred_seq.sv
// Sequential DC/TM/V/H intra predictor: captures neighbours on start, then streams one predicted row per handshake.
// Build with INTRA_PRED_DC_EN defined to include DC mode; otherwise mode 0 decodes as TM and no accumulator exists.
module intra_pred_seq #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic                            top_avail,
  input  logic                            left_avail,
  input  logic [BIT_WIDTH-1:0]            top_left,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] top,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] left,
  output logic                            busy,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0] row_data,
  output logic [$clog2(BLOCK_SIZE)-1:0]   row_idx,
  output logic                            done
);

  localparam int LOG2N = $clog2(BLOCK_SIZE);
  localparam int IDX_W = LOG2N;
  localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;
  localparam logic [BIT_WIDTH-1:0] SUB_TOP  = BIT_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic [BIT_WIDTH-1:0] SUB_LEFT = BIT_WIDTH'((1 << (BIT_WIDTH - 1)) + 1);
  localparam logic signed [BIT_WIDTH+1:0] PIX_MAX = (BIT_WIDTH + 2)'((1 << BIT_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [BIT_WIDTH-1:0] top_left_q, top_left_d;
  logic [ROW_W-1:0]     top_q, top_d;
  logic [ROW_W-1:0]     left_q, left_d;
  logic [ROW_W-1:0]     row_data_q, row_data_d;
  logic [IDX_W-1:0]     row_idx_q, row_idx_d;
  logic                 row_valid_q, row_valid_d;
  logic                 done_q, done_d;

  logic [IDX_W-1:0]            pred_idx;
  logic [BIT_WIDTH-1:0]        left_pix, top_pix, tm_pix, pix;
  logic signed [BIT_WIDTH+1:0] tm_sum;
  logic [ROW_W-1:0]            pred_row;

`ifdef INTRA_PRED_DC_EN
  localparam int ACC_W = BIT_WIDTH + LOG2N + 1;
  logic                 top_avail_q, top_avail_d;
  logic                 left_avail_q, left_avail_d;
  logic [BIT_WIDTH-1:0] dc_q, dc_d, dc_calc, dc_use;
  logic [ACC_W-1:0]     sum_top, sum_left, acc;

  // Averages only the edges that were really available; substituted edges never enter the DC value.
  always_comb begin
    sum_top  = '0;
    sum_left = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sum_top  = sum_top  + ACC_W'(top_q[i*BIT_WIDTH +: BIT_WIDTH]);
      sum_left = sum_left + ACC_W'(left_q[i*BIT_WIDTH +: BIT_WIDTH]);
    end
    acc     = '0;
    dc_calc = BIT_WIDTH'(1 << (BIT_WIDTH - 1));
    case ({top_avail_q, left_avail_q})
      2'b11: begin
        acc     = sum_top + sum_left + ACC_W'(BLOCK_SIZE);
        dc_calc = BIT_WIDTH'(acc >> (LOG2N + 1));
      end
      2'b10: begin
        acc     = sum_top + ACC_W'(BLOCK_SIZE / 2);
        dc_calc = BIT_WIDTH'(acc >> LOG2N);
      end
      2'b01: begin
        acc     = sum_left + ACC_W'(BLOCK_SIZE / 2);
        dc_calc = BIT_WIDTH'(acc >> LOG2N);
      end
      default: acc = '0;
    endcase
    dc_d   = (state_q == CALC) ? dc_calc : dc_q;
    dc_use = dc_d;
  end
`endif

  always_comb begin
    pred_idx = (state_q == CALC) ? '0 : IDX_W'(row_idx_q + 1'b1);
    left_pix = left_q[pred_idx*BIT_WIDTH +: BIT_WIDTH];
    top_pix  = '0;
    tm_sum   = '0;
    tm_pix   = '0;
    pix      = '0;
    pred_row = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      top_pix = top_q[i*BIT_WIDTH +: BIT_WIDTH];
      tm_sum  = $signed({2'b00, top_pix}) + $signed({2'b00, left_pix})
              - $signed({2'b00, top_left_q});
      if (tm_sum < 0)            tm_pix = '0;
      else if (tm_sum > PIX_MAX) tm_pix = '1;
      else                       tm_pix = tm_sum[BIT_WIDTH-1:0];
      case (mode_q)
`ifdef INTRA_PRED_DC_EN
        2'd0:    pix = dc_use;
`else
        2'd0:    pix = tm_pix;
`endif
        2'd1:    pix = tm_pix;
        2'd2:    pix = top_pix;
        default: pix = left_pix;
      endcase
      pred_row[i*BIT_WIDTH +: BIT_WIDTH] = pix;
    end
  end

  // Row 0 is formed at the end of CALC; later rows are formed on the handshake of the previous one.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    top_left_d  = top_left_q;
    top_d       = top_q;
    left_d      = left_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    row_valid_d = row_valid_q;
    done_d      = 1'b0;
`ifdef INTRA_PRED_DC_EN
    top_avail_d  = top_avail_q;
    left_avail_d = left_avail_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          mode_d     = mode;
          top_d      = top_avail  ? top  : {BLOCK_SIZE{SUB_TOP}};
          left_d     = left_avail ? left : {BLOCK_SIZE{SUB_LEFT}};
          top_left_d = !top_avail ? SUB_TOP : (!left_avail ? SUB_LEFT : top_left);
`ifdef INTRA_PRED_DC_EN
          top_avail_d  = top_avail;
          left_avail_d = left_avail;
`endif
        end
      end
      CALC: begin
        state_d     = OUT;
        row_idx_d   = '0;
        row_valid_d = 1'b1;
        row_data_d  = pred_row;
      end
      OUT: begin
        if (row_valid_q && row_ready) begin
          if (row_idx_q == IDX_W'(BLOCK_SIZE - 1)) begin
            state_d     = IDLE;
            row_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            row_idx_d  = IDX_W'(row_idx_q + 1'b1);
            row_data_d = pred_row;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      top_left_q  <= '0;
      top_q       <= '0;
      left_q      <= '0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef INTRA_PRED_DC_EN
      top_avail_q  <= 1'b0;
      left_avail_q <= 1'b0;
      dc_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      top_left_q  <= top_left_d;
      top_q       <= top_d;
      left_q      <= left_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      done_q      <= done_d;
`ifdef INTRA_PRED_DC_EN
      top_avail_q  <= top_avail_d;
      left_avail_q <= left_avail_d;
      dc_q         <= dc_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign row_valid = row_valid_q;
  assign row_data  = row_data_q;
  assign row_idx   = row_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_intra_pred_seq.sv
// Bench for intra_pred_seq: three instances (N=4, 8, 16) driven from shared buses and
// compared row by row against an arithmetic model of the prediction rules.
module tb_intra_pred_seq;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    startVec;
   logic [1:0]    mode;
   logic          topAvail, leftAvail;
   logic [7:0]    topLeft;
   logic [127:0]  topBus, leftBus;
   logic          rowReady;

   logic          busy4, valid4, done4;
   logic [31:0]   data4;
   logic [1:0]    idx4;
   logic          busy8, valid8, done8;
   logic [63:0]   data8;
   logic [2:0]    idx8;
   logic          busy16, valid16, done16;
   logic [127:0]  data16;
   logic [3:0]    idx16;

   int            checks = 0;
   int            errors = 0;
   int            curSel = 0;
   int            curN = 4;

   int            mTop[16];
   int            mLeft[16];
   int            mTl, mMode, mTopAv, mLeftAv;

   logic          obsBusy, obsValid, obsDone;
   logic [127:0]  obsData, obsIdx;

   always #5 clk = ~clk;

   intra_pred_seq #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) dut4 (
      .clk(clk), .rst(rst), .start(startVec[0]), .mode(mode),
      .top_avail(topAvail), .left_avail(leftAvail), .top_left(topLeft),
      .top(topBus[31:0]), .left(leftBus[31:0]),
      .busy(busy4), .row_valid(valid4), .row_ready(rowReady),
      .row_data(data4), .row_idx(idx4), .done(done4));

   intra_pred_seq #(.BIT_WIDTH(8), .BLOCK_SIZE(8)) dut8 (
      .clk(clk), .rst(rst), .start(startVec[1]), .mode(mode),
      .top_avail(topAvail), .left_avail(leftAvail), .top_left(topLeft),
      .top(topBus[63:0]), .left(leftBus[63:0]),
      .busy(busy8), .row_valid(valid8), .row_ready(rowReady),
      .row_data(data8), .row_idx(idx8), .done(done8));

   intra_pred_seq #(.BIT_WIDTH(8), .BLOCK_SIZE(16)) dut16 (
      .clk(clk), .rst(rst), .start(startVec[2]), .mode(mode),
      .top_avail(topAvail), .left_avail(leftAvail), .top_left(topLeft),
      .top(topBus), .left(leftBus),
      .busy(busy16), .row_valid(valid16), .row_ready(rowReady),
      .row_data(data16), .row_idx(idx16), .done(done16));

   // Route the outputs of whichever instance is under test onto one set of observation signals.
   always_comb begin
      obsBusy  = busy4;
      obsValid = valid4;
      obsDone  = done4;
      obsData  = {96'd0, data4};
      obsIdx   = {126'd0, idx4};
      if (curSel == 1) begin
         obsBusy  = busy8;
         obsValid = valid8;
         obsDone  = done8;
         obsData  = {64'd0, data8};
         obsIdx   = {125'd0, idx8};
      end else if (curSel == 2) begin
         obsBusy  = busy16;
         obsValid = valid16;
         obsDone  = done16;
         obsData  = data16;
         obsIdx   = {124'd0, idx16};
      end
   end

   // Single point of comparison: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s (N=%0d): observed %0h, expected %0h", tag, curN, observed, expected);
      end
   endtask

   // Expected row j straight from the prediction rules, using the model's copy of the neighbours.
   function automatic logic [127:0] expectedRow(input int j);
      logic [127:0] r;
      int t, l, c, v, st, sl, dc, md;
      r  = '0;
      st = 0;
      sl = 0;
      for (int i = 0; i < curN; i++) begin
         st += mTopAv  ? mTop[i]  : 127;
         sl += mLeftAv ? mLeft[i] : 129;
      end
      if (mTopAv && mLeftAv)  dc = (st + sl + curN) / (2 * curN);
      else if (mTopAv)        dc = (st + curN / 2) / curN;
      else if (mLeftAv)       dc = (sl + curN / 2) / curN;
      else                    dc = 128;
      md = mMode;
`ifndef INTRA_PRED_DC_EN
      if (md == 0) md = 1;
`endif
      l = mLeftAv ? mLeft[j] : 129;
      c = !mTopAv ? 127 : (!mLeftAv ? 129 : mTl);
      for (int i = 0; i < curN; i++) begin
         t = mTopAv ? mTop[i] : 127;
         case (md)
            0: v = dc;
            1: begin
               v = t + l - c;
               if (v < 0)   v = 0;
               if (v > 255) v = 255;
            end
            2: v = t;
            default: v = l;
         endcase
         r[i*8 +: 8] = v[7:0];
      end
      return r;
   endfunction

   // Present the model's neighbours on the buses, pulse start for one cycle, then scramble the inputs.
   task automatic applyStimulus(input int sel, input int md, input int ta, input int la, input int tl);
      curSel  = sel;
      curN    = 4 << sel;
      mMode   = md;
      mTopAv  = ta;
      mLeftAv = la;
      mTl     = tl;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         topBus[i*8 +: 8]  = mTop[i][7:0];
         leftBus[i*8 +: 8] = mLeft[i][7:0];
      end
      mode      = md[1:0];
      topAvail  = ta[0];
      leftAvail = la[0];
      topLeft   = tl[7:0];
      startVec[sel] = 1'b1;
      @(negedge clk);
      startVec  = '0;
      topBus    = {$urandom, $urandom, $urandom, $urandom};
      leftBus   = {$urandom, $urandom, $urandom, $urandom};
      topLeft   = 8'($urandom);
      mode      = 2'($urandom);
      topAvail  = 1'($urandom);
      leftAvail = 1'($urandom);
   endtask

   // Drains the block; readyMode 0 = always ready, 1 = toggling from 1, 2 = random.
   // abortAt >= 0 asserts reset once that many rows have been accepted.
   task automatic collectRows(input int readyMode, input int abortAt, input bit intrude);
      int k = 0;
      int cyc = 0;
      int doneSeen = 0;
      bit stalled = 0;
      logic [127:0] heldData = '0;
      logic [127:0] heldIdx = '0;
      checkOutput("busyAfterStart", {127'd0, obsBusy}, 128'd1);
      checkOutput("noRowInCalc", {127'd0, obsValid}, 128'd0);
      while (k < curN && cyc < 300) begin
         @(negedge clk);
         cyc++;
         case (readyMode)
            0:       rowReady = 1'b1;
            1:       rowReady = (cyc % 2) == 1;
            default: rowReady = 1'($urandom_range(0, 1));
         endcase
         if (intrude && cyc == 3) begin
            startVec[curSel] = 1'b1;
            mode    = 2'd3;
            topBus  = {$urandom, $urandom, $urandom, $urandom};
            leftBus = {$urandom, $urandom, $urandom, $urandom};
         end
         if (intrude && cyc == 4) startVec = '0;
         if (obsDone) doneSeen++;
         if (stalled) begin
            checkOutput("stallDataHeld", obsData, heldData);
            checkOutput("stallIdxHeld", obsIdx, heldIdx);
         end
         stalled = 0;
         if (obsValid) begin
            if (readyMode == 0) checkOutput("rowTiming", 128'(cyc), 128'(k + 1));
            if (rowReady) begin
               checkOutput($sformatf("rowData%0d", k), obsData, expectedRow(k));
               checkOutput($sformatf("rowIdx%0d", k), obsIdx, 128'(k));
               k++;
            end else begin
               stalled  = 1;
               heldData = obsData;
               heldIdx  = obsIdx;
            end
         end
         if (abortAt >= 0 && k == abortAt) break;
      end
      if (abortAt >= 0) begin
         @(negedge clk);
         rst = 1'b1;
         #1;
         checkOutput("abortBusy", {127'd0, obsBusy}, 128'd0);
         checkOutput("abortValid", {127'd0, obsValid}, 128'd0);
         checkOutput("abortData", obsData, 128'd0);
         checkOutput("abortIdx", obsIdx, 128'd0);
         checkOutput("abortDone", {127'd0, obsDone}, 128'd0);
         @(negedge clk);
         rst = 1'b0;
         repeat (4) begin
            @(negedge clk);
            if (obsDone) doneSeen++;
         end
         checkOutput("abortNoDone", 128'(doneSeen), 128'd0);
         return;
      end
      checkOutput("rowsDelivered", 128'(k), 128'(curN));
      checkOutput("noEarlyDone", 128'(doneSeen), 128'd0);
      @(negedge clk);
      checkOutput("donePulse", {127'd0, obsDone}, 128'd1);
      checkOutput("busyCleared", {127'd0, obsBusy}, 128'd0);
      checkOutput("validCleared", {127'd0, obsValid}, 128'd0);
      @(negedge clk);
      checkOutput("doneSingleCycle", {127'd0, obsDone}, 128'd0);
   endtask

   task automatic fillUniform(input int t, input int l);
      for (int i = 0; i < 16; i++) begin
         mTop[i]  = t;
         mLeft[i] = l;
      end
   endtask

   initial begin
      rst       = 1'b1;
      startVec  = '0;
      mode      = '0;
      topAvail  = 1'b0;
      leftAvail = 1'b0;
      topLeft   = '0;
      topBus    = '0;
      leftBus   = '0;
      rowReady  = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         curSel = s;
         curN   = 4 << s;
         #1;
         checkOutput("resetBusy", {127'd0, obsBusy}, 128'd0);
         checkOutput("resetValid", {127'd0, obsValid}, 128'd0);
         checkOutput("resetData", obsData, 128'd0);
         checkOutput("resetIdx", obsIdx, 128'd0);
         checkOutput("resetDone", {127'd0, obsDone}, 128'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] N=4 TM nominal, both edges");
      fillUniform(200, 100);
      applyStimulus(0, 1, 1, 1, 50);
      collectRows(0, -1, 0);

      $display("[TB] N=4 TM clamp high and low");
      fillUniform(250, 250);
      applyStimulus(0, 1, 1, 1, 10);
      collectRows(0, -1, 0);
      fillUniform(5, 5);
      applyStimulus(0, 1, 1, 1, 200);
      collectRows(0, -1, 0);

      $display("[TB] N=4 mode 0 with both edges and with none");
      fillUniform(10, 20);
      applyStimulus(0, 0, 1, 1, 33);
      collectRows(0, -1, 0);
      applyStimulus(0, 0, 0, 0, 33);
      collectRows(0, -1, 0);

      $display("[TB] N=16 H mode, toggling ready");
      for (int i = 0; i < 16; i++) begin
         mTop[i]  = $urandom_range(0, 255);
         mLeft[i] = i;
      end
      applyStimulus(2, 3, 1, 1, 77);
      collectRows(1, -1, 0);

      $display("[TB] N=8 V mode without top, second start during output");
      fillUniform(60, 90);
      applyStimulus(1, 2, 0, 1, 40);
      collectRows(0, -1, 1);

      $display("[TB] N=8 reset mid-block, then a fresh block");
      for (int i = 0; i < 16; i++) begin
         mTop[i]  = $urandom_range(0, 255);
         mLeft[i] = $urandom_range(0, 255);
      end
      applyStimulus(1, 1, 1, 1, 128);
      collectRows(0, 4, 0);
      applyStimulus(1, 1, 1, 1, 128);
      collectRows(0, -1, 0);

      $display("[TB] randomized blocks");
      for (int b = 0; b < 24; b++) begin
         for (int i = 0; i < 16; i++) begin
            mTop[i]  = $urandom_range(0, 255);
            mLeft[i] = $urandom_range(0, 255);
         end
         applyStimulus($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 255));
         collectRows($urandom_range(0, 2), -1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
